// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - dpram port A arbiter between Z80 bus and ESP32 SPI slave
// Optional RAM_ARB_STATS_EN adds saturating stat_grants / stat_stall counters.
module ram_port_arbiter #(
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_load,
  input  logic                 spi_wr,
  input  logic                 spi_rd,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [DATA_BITS-1:0] spi_wdata,
  output logic [DATA_BITS-1:0] spi_rdata,
  output logic                 spi_rvalid,
  output logic                 spi_ovf,
  input  logic                 cpu_mreq,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic [DATA_BITS-1:0] cpu_rdata,
  output logic                 cpu_wait_n,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_grants,
  output logic [15:0]          stat_stall
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_SPI_ISSUE,
    ST_SPI_CAPTURE,
    ST_LOAD
  } state_t;

  state_t state, state_n;

  logic                 pend;
  logic                 pend_wr;
  logic [ADDR_BITS-1:0] pend_addr;
  logic [DATA_BITS-1:0] pend_wdata;
  logic                 cap_rd;
  logic                 prev_cpu;
  logic [SW-1:0]        starve;

  logic strobe, accept, req, cpu_write, starved;

  // The slot frees on the ISSUE edge, so a strobe landing in ISSUE refills it.
  assign strobe    = spi_rd | spi_wr;
  assign accept    = strobe & (~pend | (state == ST_SPI_ISSUE));
  assign req       = pend | accept;
  assign cpu_write = cpu_mreq & cpu_we;
  assign starved   = (starve == STARVE_MAX);

  always_comb begin
    state_n = state;
    case (state)
      ST_CPU: begin
        if (req && (!cpu_write || starved || spi_load)) state_n = ST_SPI_ISSUE;
        else if (spi_load)                              state_n = ST_LOAD;
      end
      ST_SPI_ISSUE: state_n = ST_SPI_CAPTURE;
      ST_SPI_CAPTURE: begin
        if (spi_load) state_n = req ? ST_SPI_ISSUE : ST_LOAD;
        else          state_n = ST_CPU;
      end
      ST_LOAD: begin
        if (req)           state_n = ST_SPI_ISSUE;
        else if (!spi_load) state_n = ST_CPU;
      end
      default: state_n = ST_CPU;
    endcase
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = pend_addr;
    ram_din  = pend_wdata;
    if (state == ST_CPU) begin
      ram_we   = cpu_write;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end else if (state == ST_SPI_ISSUE) begin
      ram_we = pend_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CPU;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      spi_ovf    <= 1'b0;
      cap_rd     <= 1'b0;
      spi_rdata  <= '0;
      spi_rvalid <= 1'b0;
      starve     <= '0;
      prev_cpu   <= 1'b1;
      cpu_rdata  <= '0;
      cpu_wait_n <= 1'b1;
    end else begin
      if (accept) begin
        pend       <= 1'b1;
        pend_wr    <= spi_wr;
        pend_addr  <= spi_addr;
        pend_wdata <= spi_wdata;
      end else if (state == ST_SPI_ISSUE) begin
        pend <= 1'b0;
      end
      if (strobe && !accept) spi_ovf <= 1'b1;

      if (state == ST_SPI_ISSUE) cap_rd <= ~pend_wr;
      spi_rvalid <= (state == ST_SPI_CAPTURE) & cap_rd;
      if (state == ST_SPI_CAPTURE && cap_rd) spi_rdata <= ram_dout;

      if (state_n == ST_SPI_ISSUE)                     starve <= '0;
      else if (pend && state == ST_CPU && !starved)    starve <= starve + SW'(1);

      // ram_dout reflects the previous cycle's address; only trust it if the CPU owned it.
      prev_cpu <= (state == ST_CPU);
      if (prev_cpu) cpu_rdata <= ram_dout;
      cpu_wait_n <= (state == ST_CPU);
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      if (state_n == ST_SPI_ISSUE && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
      if (pend && stat_stall != 16'hFFFF)                     stat_stall  <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
